// File: rtl/wb_zamanlayici_if.sv
// Wishbone B4 classic single-beat bus bundle between the core bridge (master)
// and the timer peripheral (slave).
interface wb_zamanlayici_if #(
    parameter int ADRES_GENISLIGI  = 8,
    parameter int SOZCUK_GENISLIGI = 32
);
    logic [ADRES_GENISLIGI-1:0]  wbs_adr_i;
    logic [SOZCUK_GENISLIGI-1:0] wbs_dat_i;
    logic [SOZCUK_GENISLIGI-1:0] wbs_dat_o;
    logic                        wbs_we_i;
    logic                        wbs_stb_i;
    logic                        wbs_cyc_i;
    logic                        wbs_ack_o;

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
        output wbs_dat_o, wbs_ack_o
    );

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
        input  wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/wb_zamanlayici.sv
// Wishbone slave timer: prescaled 32-bit up-counter with compare match,
// optional auto-reload, sticky match flag and level interrupt.
module wb_zamanlayici #(
    parameter int ADRES_GENISLIGI     = 8,
    parameter int SOZCUK_GENISLIGI    = 32,
    parameter int ON_BOLUCU_GENISLIGI = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_zamanlayici_if.slave  wb,
    output logic             kesme_o
);
    localparam int KW = ADRES_GENISLIGI - 2;
    localparam int DW = SOZCUK_GENISLIGI;
    localparam int PW = ON_BOLUCU_GENISLIGI;

    localparam logic [KW-1:0] K_KONTROL   = KW'(0);
    localparam logic [KW-1:0] K_ON_BOLUCU = KW'(1);
    localparam logic [KW-1:0] K_SAYAC     = KW'(2);
    localparam logic [KW-1:0] K_KARSI     = KW'(3);
    localparam logic [KW-1:0] K_DURUM     = KW'(4);

    typedef enum logic [0:0] {BOSTA = 1'b0, ACK = 1'b1} durum_t;

    durum_t          durum_r;
    durum_t          durum_s;
    logic            ack_r;
    logic [DW-1:0]   dat_r;
    logic            etkin_r;
    logic            oto_r;
    logic            kesme_etkin_r;
    logic [PW-1:0]   on_bolucu_r;
    logic [PW-1:0]   on_sayac_r;
    logic [DW-1:0]   sayac_r;
    logic [DW-1:0]   karsi_r;
    logic            eslesme_r;

    logic [KW-1:0]   kelime_s;
    logic            erisim_s;
    logic            oku_s;
    logic            yaz_s;
    logic            tik_s;
    logic            esit_s;
    logic [DW-1:0]   okuma_s;
    logic            adres_unused_s;

    assign kelime_s       = wb.wbs_adr_i[ADRES_GENISLIGI-1:2];
    assign adres_unused_s = ^wb.wbs_adr_i[1:0];
    assign erisim_s       = (durum_r == BOSTA) && wb.wbs_stb_i && wb.wbs_cyc_i;
    assign oku_s          = erisim_s && !wb.wbs_we_i;
    assign yaz_s          = erisim_s && wb.wbs_we_i;
    assign tik_s          = etkin_r && (on_sayac_r == on_bolucu_r);
    assign esit_s         = (sayac_r == karsi_r);

    assign wb.wbs_ack_o = ack_r;
    assign wb.wbs_dat_o = dat_r;
    // Both operands are flops, so the interrupt has no path from the bus inputs.
    assign kesme_o      = eslesme_r && kesme_etkin_r;

    // Bus FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_r <= BOSTA;
        end else begin
            durum_r <= durum_s;
        end
    end

    // Bus FSM next state: one ack cycle per accepted strobe, then idle again
    always_comb begin
        durum_s = durum_r;
        case (durum_r)
            BOSTA: begin
                if (wb.wbs_stb_i && wb.wbs_cyc_i) begin
                    durum_s = ACK;
                end else begin
                    durum_s = BOSTA;
                end
            end
            ACK:     durum_s = BOSTA;
            default: durum_s = BOSTA;
        endcase
    end

    // Read data mux; unmapped offsets and unused bits read as zero
    always_comb begin
        okuma_s = '0;
        case (kelime_s)
            K_KONTROL:   okuma_s = {{(DW-3){1'b0}}, kesme_etkin_r, oto_r, etkin_r};
            K_ON_BOLUCU: okuma_s = DW'(on_bolucu_r);
            K_SAYAC:     okuma_s = sayac_r;
            K_KARSI:     okuma_s = karsi_r;
            K_DURUM:     okuma_s = {{(DW-1){1'b0}}, eslesme_r};
            default:     okuma_s = '0;
        endcase
    end

    // Registered ack and read data; data holds outside the ack cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r <= 1'b0;
            dat_r <= '0;
        end else begin
            ack_r <= erisim_s;
            if (oku_s) begin
                dat_r <= okuma_s;
            end else begin
                dat_r <= dat_r;
            end
        end
    end

    // Prescaler counter: free-runs while enabled and restarts on every tik
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_sayac_r <= '0;
        end else if (!etkin_r || tik_s) begin
            on_sayac_r <= '0;
        end else begin
            on_sayac_r <= on_sayac_r + PW'(1);
        end
    end

    // Timer registers; later assignments win, giving bus writes and match-set priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            etkin_r       <= 1'b0;
            oto_r         <= 1'b0;
            kesme_etkin_r <= 1'b0;
            on_bolucu_r   <= '0;
            sayac_r       <= '0;
            karsi_r       <= '0;
            eslesme_r     <= 1'b0;
        end else begin
            if (yaz_s && (kelime_s == K_DURUM) && wb.wbs_dat_i[0]) begin
                eslesme_r <= 1'b0;
            end
            if (tik_s) begin
                if (esit_s) begin
                    eslesme_r <= 1'b1;
                    if (oto_r) begin
                        sayac_r <= '0;
                    end else begin
                        etkin_r <= 1'b0;
                    end
                end else begin
                    sayac_r <= sayac_r + DW'(1);
                end
            end
            if (yaz_s) begin
                case (kelime_s)
                    K_KONTROL: begin
                        etkin_r       <= wb.wbs_dat_i[0];
                        oto_r         <= wb.wbs_dat_i[1];
                        kesme_etkin_r <= wb.wbs_dat_i[2];
                    end
                    K_ON_BOLUCU: on_bolucu_r <= wb.wbs_dat_i[PW-1:0];
                    K_SAYAC:     sayac_r     <= wb.wbs_dat_i;
                    K_KARSI:     karsi_r     <= wb.wbs_dat_i;
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wb_zamanlayici.sv
// Directed self-checking bench for wb_zamanlayici: register access, free-running,
// one-shot, wrap, collision and reset-during-ack scenarios.
module tb_wb_zamanlayici;
    localparam logic [7:0] A_KONTROL   = 8'h00;
    localparam logic [7:0] A_ON_BOLUCU = 8'h04;
    localparam logic [7:0] A_SAYAC     = 8'h08;
    localparam logic [7:0] A_KARSI     = 8'h0C;
    localparam logic [7:0] A_DURUM     = 8'h10;
    localparam logic [7:0] A_BOS       = 8'h20;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic kesme_o;
    int   kenar_say = 0;
    int   son_kenar = 0;
    int   kontrol_say = 0;
    int   hata_say = 0;
    int   w;

    wb_zamanlayici_if #(.ADRES_GENISLIGI(8), .SOZCUK_GENISLIGI(32)) wb ();

    wb_zamanlayici dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wb      (wb),
        .kesme_o (kesme_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) kenar_say <= kenar_say + 1;

    initial begin
        #1000000;
        $display("FAIL zaman_asimi: gozlenen=asim beklenen=bitis");
        $fatal(1, "timeout");
    end

    task automatic kontrol_et(input string etiket, input logic [31:0] gozlenen,
                              input logic [31:0] beklenen);
        kontrol_say++;
        if (gozlenen !== beklenen) begin
            hata_say++;
            $display("FAIL %s: gozlenen=0x%08h beklenen=0x%08h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic bus_islem(input logic yaz, input logic [7:0] adr, input logic [31:0] veri,
                             output logic [31:0] okunan);
        int bekle;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = veri;
        wb.wbs_we_i  = yaz;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        bekle = 0;
        do begin
            @(posedge clk_i);
            #1;
            bekle++;
        end while (!wb.wbs_ack_o && bekle < 4);
        kontrol_et("ack_gecikme", bekle, 1);
        son_kenar = kenar_say;
        okunan = wb.wbs_dat_o;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(posedge clk_i);
        #1;
        kontrol_et("ack_tek_cevrim", {31'd0, wb.wbs_ack_o}, 32'd0);
    endtask

    task automatic yaz(input logic [7:0] adr, input logic [31:0] veri);
        logic [31:0] bos;
        bus_islem(1'b1, adr, veri, bos);
    endtask

    task automatic oku_kontrol(input string etiket, input logic [7:0] adr,
                               input logic [31:0] beklenen);
        logic [31:0] okunan;
        bus_islem(1'b0, adr, 32'd0, okunan);
        kontrol_et(etiket, okunan, beklenen);
    endtask

    // Wait until n edges have passed, then sit 1 time unit after edge n.
    task automatic bekle_kenar(input int n);
        if (kenar_say > n) kontrol_et("zamanlama", kenar_say, n);
        while (kenar_say < n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Read whose strobe is captured at edge n, i.e. sees the state after edge n-1.
    task automatic oku_kenarda(input string etiket, input logic [7:0] adr, input int n,
                               input logic [31:0] beklenen);
        bekle_kenar(n - 1);
        oku_kontrol(etiket, adr, beklenen);
    endtask

    task automatic sifirla();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        wb.wbs_adr_i = 8'h00;
        wb.wbs_dat_i = 32'd0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        sifirla();

        // Reset state of every offset
        kontrol_et("reset_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
        kontrol_et("reset_kesme", {31'd0, kesme_o}, 32'd0);
        oku_kontrol("reset_kontrol", A_KONTROL, 32'd0);
        oku_kontrol("reset_on_bolucu", A_ON_BOLUCU, 32'd0);
        oku_kontrol("reset_sayac", A_SAYAC, 32'd0);
        oku_kontrol("reset_karsi", A_KARSI, 32'd0);
        oku_kontrol("reset_durum", A_DURUM, 32'd0);
        oku_kontrol("reset_bos", A_BOS, 32'd0);

        // Register read-back and unmapped write
        yaz(A_KARSI, 32'hA5A5A5A5);
        oku_kontrol("karsi_geri_oku", A_KARSI, 32'hA5A5A5A5);
        yaz(A_BOS, 32'hFFFFFFFF);
        oku_kontrol("bos_yaz_oku", A_BOS, 32'd0);
        oku_kontrol("bos_yaz_kontrol", A_KONTROL, 32'd0);
        oku_kontrol("bos_yaz_karsi", A_KARSI, 32'hA5A5A5A5);
        yaz(A_ON_BOLUCU, 32'hFFFF1234);
        oku_kontrol("on_bolucu_genislik", A_ON_BOLUCU, 32'h00001234);

        // Free-running with auto-reload: tik every 4 cycles, match at SAYAC==2
        sifirla();
        yaz(A_ON_BOLUCU, 32'd3);
        yaz(A_KARSI, 32'd2);
        yaz(A_KONTROL, 32'h7);
        w = son_kenar;
        oku_kenarda("serbest_sayac_1", A_SAYAC, w + 5, 32'd1);
        oku_kenarda("serbest_sayac_2", A_SAYAC, w + 9, 32'd2);
        bekle_kenar(w + 11);
        kontrol_et("serbest_kesme_once", {31'd0, kesme_o}, 32'd0);
        bekle_kenar(w + 12);
        kontrol_et("serbest_kesme_eslesme", {31'd0, kesme_o}, 32'd1);
        oku_kenarda("serbest_durum", A_DURUM, w + 13, 32'd1);
        oku_kenarda("serbest_yeniden_yukle", A_SAYAC, w + 15, 32'd0);

        // One-shot: counter holds and hardware clears etkin
        sifirla();
        yaz(A_ON_BOLUCU, 32'd3);
        yaz(A_KARSI, 32'd2);
        yaz(A_KONTROL, 32'h5);
        w = son_kenar;
        bekle_kenar(w + 12);
        kontrol_et("tek_kesme", {31'd0, kesme_o}, 32'd1);
        oku_kenarda("tek_kontrol", A_KONTROL, w + 13, 32'h4);
        oku_kenarda("tek_sayac_tutar", A_SAYAC, w + 15, 32'd2);
        oku_kenarda("tek_sayac_sonra", A_SAYAC, w + 25, 32'd2);
        yaz(A_DURUM, 32'h1);
        oku_kontrol("tek_w1c_durum", A_DURUM, 32'd0);
        kontrol_et("tek_w1c_kesme", {31'd0, kesme_o}, 32'd0);

        // Wrap from all-ones, no flag until the compare value
        sifirla();
        yaz(A_SAYAC, 32'hFFFFFFFF);
        yaz(A_ON_BOLUCU, 32'd0);
        yaz(A_KARSI, 32'd5);
        yaz(A_KONTROL, 32'h1);
        w = son_kenar;
        oku_kenarda("tasma_sayac", A_SAYAC, w + 2, 32'd0);
        oku_kenarda("tasma_durum_yok", A_DURUM, w + 4, 32'd0);
        oku_kenarda("tasma_sayac_4", A_SAYAC, w + 6, 32'd4);
        oku_kenarda("tasma_durum_var", A_DURUM, w + 8, 32'd1);
        kontrol_et("tasma_kesme_kapali", {31'd0, kesme_o}, 32'd0);

        // Bus write to SAYAC collides with a tik
        sifirla();
        yaz(A_KARSI, 32'hFFFFFFFF);
        yaz(A_KONTROL, 32'h1);
        yaz(A_SAYAC, 32'h100);
        w = son_kenar;
        oku_kenarda("carpisma_sayac_1", A_SAYAC, w + 2, 32'h101);
        oku_kenarda("carpisma_sayac_3", A_SAYAC, w + 4, 32'h103);

        // W1C in the match cycle loses; W1C elsewhere clears
        sifirla();
        yaz(A_KARSI, 32'd3);
        yaz(A_KONTROL, 32'h7);
        w = son_kenar;
        bekle_kenar(w + 3);
        yaz(A_DURUM, 32'h1);
        oku_kenarda("w1c_eslesmede", A_DURUM, w + 6, 32'd1);
        bekle_kenar(w + 9);
        yaz(A_DURUM, 32'h1);
        oku_kenarda("w1c_normal", A_DURUM, w + 12, 32'd0);

        // Reset asserted during the ack cycle
        sifirla();
        yaz(A_KARSI, 32'h55);
        yaz(A_KONTROL, 32'h7);
        wb.wbs_adr_i = A_KARSI;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        @(posedge clk_i);
        #1;
        kontrol_et("rst_ack_once", {31'd0, wb.wbs_ack_o}, 32'd1);
        rst_i = 1'b1;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        @(posedge clk_i);
        #1;
        kontrol_et("rst_ack_sonra", {31'd0, wb.wbs_ack_o}, 32'd0);
        rst_i = 1'b0;
        oku_kontrol("rst_karsi", A_KARSI, 32'd0);
        oku_kontrol("rst_kontrol", A_KONTROL, 32'd0);
        oku_kontrol("rst_sayac", A_SAYAC, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", kontrol_say, hata_say);
        $finish;
    end
endmodule
